// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: single-outstanding instruction fetch bridge with a one-entry hit buffer
module inst_fetch_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  CE,
  input  logic                  FLUSH,
  output logic [INST_WIDTH-1:0] INST,
  output logic                  INST_VALID,
  output logic                  STALL_REQ,
  output logic                  ADDR_ERR,
  output logic                  INST_REQ,
  output logic [ADDR_WIDTH-1:0] INST_ADDR,
  input  logic                  INST_ADDR_OK,
  input  logic                  INST_DATA_OK,
  input  logic [INST_WIDTH-1:0] INST_RDATA
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                  state;
  logic                    drop;
  logic                    held_valid;
  logic [ADDR_WIDTH-1:0]   held_pc;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [INST_WIDTH-1:0]   held_inst;
  logic                    aligned;
  logic                    idle;
  logic                    hit;
  logic                    miss;
  // Match the PC against the buffer; every output is held low while reset is asserted
  always_comb begin
    aligned    = PC[1:0] == 2'b00;
    idle       = RST && state == IDLE;
    hit        = idle && CE && aligned && held_valid && held_pc == PC;
    miss       = idle && CE && aligned && !hit && !FLUSH;
    INST_VALID = hit;
    INST       = hit ? held_inst : '0;
    STALL_REQ  = miss || (RST && state != IDLE);
    ADDR_ERR   = RST && CE && !aligned;
    INST_REQ   = state == ADDR;
    INST_ADDR  = state == ADDR ? addr_reg : '0;
  end
  // Fetch handshake: launch on a miss, hold the request until accepted, buffer or drop the data
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state      <= IDLE;
      drop       <= 1'b0;
      held_valid <= 1'b0;
      held_pc    <= '0;
      held_inst  <= '0;
      addr_reg   <= '0;
    end else
      case (state)
        IDLE: begin
          if (FLUSH) held_valid <= 1'b0;
          if (miss) begin
            addr_reg <= PC;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (FLUSH) drop <= 1'b1;
          if (INST_ADDR_OK) state <= DATA;
        end
        DATA:
          if (INST_DATA_OK) begin
            if (drop || FLUSH) held_valid <= 1'b0;
            else begin
              held_valid <= 1'b1;
              held_pc    <= addr_reg;
              held_inst  <= INST_RDATA;
            end
            drop  <= 1'b0;
            state <= IDLE;
          end else if (FLUSH) drop <= 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed and randomized checks of the fetch bridge against a transaction-level model
module tb_inst_fetch_bridge;
  localparam int AW = 32;
  localparam int IW = 32;
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [AW-1:0] PC = '0;
  logic          CE = 1'b0;
  logic          FLUSH = 1'b0;
  logic [IW-1:0] INST;
  logic          INST_VALID;
  logic          STALL_REQ;
  logic          ADDR_ERR;
  logic          INST_REQ;
  logic [AW-1:0] INST_ADDR;
  logic          INST_ADDR_OK = 1'b0;
  logic          INST_DATA_OK = 1'b0;
  logic [IW-1:0] INST_RDATA = '0;
  int checks = 0;
  int failures = 0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_pc = '0;
  logic [IW-1:0] m_inst = '0;
  always #5 CLK = ~CLK;
  inst_fetch_bridge #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .CE(CE), .FLUSH(FLUSH),
    .INST(INST), .INST_VALID(INST_VALID), .STALL_REQ(STALL_REQ), .ADDR_ERR(ADDR_ERR),
    .INST_REQ(INST_REQ), .INST_ADDR(INST_ADDR), .INST_ADDR_OK(INST_ADDR_OK),
    .INST_DATA_OK(INST_DATA_OK), .INST_RDATA(INST_RDATA)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [IW-1:0] inst, input logic v, input logic st,
                         input logic ae, input logic rq, input logic ca, input logic [AW-1:0] ad);
    chk({tag, "_inst"}, INST, inst);
    chk({tag, "_valid"}, INST_VALID, v);
    chk({tag, "_stall"}, STALL_REQ, st);
    chk({tag, "_aerr"}, ADDR_ERR, ae);
    chk({tag, "_req"}, INST_REQ, rq);
    if (ca) chk({tag, "_addr"}, INST_ADDR, ad);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic serve(input logic [AW-1:0] pc, input logic [IW-1:0] rd, input int ad, input int dd,
                       input int fa, input int fd);
    int accepted;
    bit dropped;
    accepted = 0;
    dropped = 0;
    for (int i = 0; i <= ad; i++) begin
      CE = $urandom_range(0, 1);
      PC = $urandom;
      INST_ADDR_OK = (i == ad);
      INST_DATA_OK = $urandom_range(0, 1);
      INST_RDATA = $urandom;
      FLUSH = (i == fa);
      @(negedge CLK);
      chk_out("addr", '0, 1'b0, 1'b1, CE && PC[1:0] != 2'b00, 1'b1, 1'b1, pc);
      if (INST_REQ && INST_ADDR_OK) accepted++;
      if (FLUSH) dropped = 1;
      tick();
    end
    for (int j = 0; j <= dd; j++) begin
      CE = $urandom_range(0, 1);
      PC = $urandom;
      INST_DATA_OK = (j == dd);
      INST_ADDR_OK = $urandom_range(0, 1);
      INST_RDATA = (j == dd) ? rd : IW'($urandom);
      FLUSH = (j == fd);
      @(negedge CLK);
      chk_out("data", '0, 1'b0, 1'b1, CE && PC[1:0] != 2'b00, 1'b0, 1'b0, '0);
      if (INST_REQ && INST_ADDR_OK) accepted++;
      if (FLUSH) dropped = 1;
      tick();
    end
    INST_DATA_OK = 1'b0;
    INST_ADDR_OK = 1'b0;
    FLUSH = 1'b0;
    chk("one_request", accepted, 1);
    if (dropped) m_valid = 1'b0;
    else begin
      m_valid = 1'b1;
      m_pc = pc;
      m_inst = rd;
    end
  endtask
  task automatic access(input logic [AW-1:0] pc, input logic ce, input logic fl, input logic [IW-1:0] rd,
                        input int ad, input int dd, input int fa, input int fd);
    logic al, hit, miss;
    al = pc[1:0] == 2'b00;
    hit = ce && al && m_valid && m_pc == pc;
    miss = ce && al && !hit && !fl;
    PC = pc;
    CE = ce;
    FLUSH = fl;
    INST_ADDR_OK = $urandom_range(0, 1);
    INST_DATA_OK = $urandom_range(0, 1);
    INST_RDATA = $urandom;
    @(negedge CLK);
    chk_out("idle", hit ? m_inst : '0, hit, miss, ce && !al, 1'b0, 1'b0, '0);
    tick();
    FLUSH = 1'b0;
    if (fl) m_valid = 1'b0;
    if (miss) serve(pc, rd, ad, dd, fa, fd);
  endtask
  initial begin
    logic [AW-1:0] pcs [5];
    pcs = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h42};
    CE = 1'b1;
    #2;
    chk_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (2) tick();
    RST = 1'b1;
    access(32'h0, 1, 0, 32'h3C011234, 0, 0, -1, -1);
    access(32'h0, 1, 0, 32'h0, 0, 0, -1, -1);
    chk("hit_inst", INST, 32'h3C011234);
    access(32'h4, 1, 0, $urandom, 3, 0, -1, -1);
    access(32'h4, 1, 0, 32'h0, 0, 0, -1, -1);
    access(32'h8, 1, 0, 32'hDEADBEEF, 0, 2, -1, 1);
    access(32'h40, 1, 0, $urandom, 0, 0, -1, -1);
    access(32'hC, 1, 0, $urandom, 2, 1, 1, -1);
    access(32'hC, 1, 0, $urandom, 0, 0, -1, 0);
    access(32'h2, 1, 0, $urandom, 0, 0, -1, -1);
    access($urandom, 0, 0, $urandom, 0, 0, -1, -1);
    access(32'h40, 1, 0, $urandom, 1, 1, -1, -1);
    access(32'h40, 1, 1, $urandom, 0, 0, -1, -1);
    access(32'h40, 1, 0, $urandom, 0, 0, -1, -1);
    PC = 32'h10;
    CE = 1'b1;
    @(negedge CLK);
    chk("rm_miss_stall", STALL_REQ, 1);
    tick();
    INST_ADDR_OK = 1'b1;
    @(negedge CLK);
    chk("rm_req", INST_REQ, 1);
    tick();
    INST_ADDR_OK = 1'b0;
    @(negedge CLK);
    chk("rm_data_stall", STALL_REQ, 1);
    #1 RST = 1'b0;
    #1 chk_out("rm_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    m_valid = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    CE = 1'b0;
    INST_DATA_OK = 1'b1;
    INST_RDATA = 32'h12345678;
    @(negedge CLK);
    chk_out("rm_late_ok", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    INST_DATA_OK = 1'b0;
    access(32'h10, 1, 0, $urandom, 0, 0, -1, -1);
    for (int k = 0; k < 80; k++) begin
      int ad, dd, fa, fd;
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ad)) : -1;
      fd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dd)) : -1;
      access(pcs[$urandom_range(0, 4)], $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             $urandom, ad, dd, fa, fd);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
